interp_row_scheduler: RTL and testbench
=======================================

Name: interp_row_scheduler

Overview:
- Sequences one row of HEVC luma sub-pixel interpolation through the shared 8-tap FIR bank (quarter, half and three-quarter filters).
- Accepts integer pixels on a valid/ready stream and maintains the 8-pixel sliding window. Issues one window per output position with the filter select, then collects the registered filter results into an output stream.
- The FIR bank has a fixed latency and cannot stall. The block therefore enforces output backpressure with credit-based issue into a small result buffer.
- Sits between the reference-pixel fetch and the horizontal/vertical sample writer.

Parameters:
- ROW_W, 8, output samples per row; legal range 4..64.
- FIR_LAT, 1, clock cycles from win_valid to the matching fir_subpixel; legal range 1..4.
- OBUF_DEPTH, 4, result buffer entries; must be >= FIR_LAT+1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a row; ignored unless idle.
- frac  in  2  fractional position, latched at start: 0 integer, 1 quarter, 2 half, 3 three-quarter.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last output is popped.
- pix_valid  in  1  input pixel valid.
- pix_ready  out  1  input pixel ready.
- pix_data  in  8  integer pixel, left to right.
- win_valid  out  1  window issue strobe to the FIR bank.
- win_data  out  64  window; [7:0] is the oldest tap (p[i-3]), [63:56] the newest (p[i+4]).
- win_sel  out  2  copy of the latched frac; selects the FIR bank output mux.
- fir_subpixel  in  8  selected FIR result; valid exactly FIR_LAT cycles after win_valid.
- out_valid  out  1  result valid.
- out_ready  in  1  result ready.
- out_data  out  8  sub-pixel sample.
- out_last  out  1  high with the ROW_W-th output of the row.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - All outputs go to 0; win_data goes to 0.
  - State returns to IDLE.
  - Window, counters, in-flight tag pipe and result buffer are cleared.
  - Reset mid-row discards all in-flight and buffered results; done is not pulsed.
- States:
  - IDLE -> PRELOAD on start. The start cycle latches frac and clears the counters.
  - PRELOAD accepts 7 pixels and issues nothing. -> RUN after the 7th accept.
  - RUN accepts one pixel per handshake and issues one window per accept. -> DRAIN after issue number ROW_W.
  - DRAIN accepts no pixels. -> IDLE after the last output pop; done pulses in that same cycle (registered).
- Row input size: exactly ROW_W+7 pixels are consumed per row. Output i uses p[i..i+7], centre p[i+3].
- Window: an 8-byte shift register. On each accept it shifts toward [7:0] and loads pix_data into [63:56].
- Issue timing:
  - win_valid is registered and asserted the cycle after a RUN accept, with the updated window.
  - win_data holds its value when win_valid is low.
- Credits:
  - credits = OBUF_DEPTH − (buffer occupancy + windows in flight).
  - pix_ready = (state==PRELOAD) or (state==RUN and credits>0 and issued<ROW_W).
  - A pop and an issue in the same cycle both update the count; the net change is 0.
  - The buffer never overflows. Overflow is an assertion failure.
- In-flight tracking: a FIR_LAT-deep valid/last tag pipe aligned with the FIR latency. When a tag emerges, fir_subpixel is written into the buffer.
- frac=0 (integer position):
  - The window is still issued and the tag pipe is used.
  - The captured value is window byte [31:24] (p[i+3]), delayed through an internal FIR_LAT-deep byte pipe, instead of fir_subpixel.
  - Ordering and latency are identical to the filtered modes.
- Output buffer:
  - FIFO, first-word fall-through.
  - out_valid = not empty; a pop occurs when out_valid and out_ready are both high.
  - out_data and out_last come from the head entry.
  - Simultaneous write and pop are legal when full or empty.
- start while busy is ignored.
- pix_valid outside PRELOAD/RUN is ignored. Pixels are never consumed without pix_ready.

Decomposition:
- Shared package interp_pkg:
  - frac encoding constants: FRAC_INT, FRAC_Q, FRAC_H, FRAC_3Q.
  - FIR tap count 8 and pre-window length 7.
  - state encoding: IDLE, PRELOAD, RUN, DRAIN.
- One sub-module: interp_result_fifo, a parameterised depth, 9-bit (data+last) first-word-fall-through FIFO with count output.

Test Plan:
- frac=0, ramp pixels 0..14, ROW_W=8, out_ready=1:
  - outputs are 3,4,...,10; out_last only on 10.
  - done pulses one cycle after the last pop; exactly 15 pixels are accepted.
- frac=2, constant pixels 100, with a behavioural FIR model (latency FIR_LAT) attached:
  - 8 outputs of 100.
  - win_sel=2 throughout; win_data on the first issue is 64'h6464646464646464.
- frac=1, step input (7 pixels of 0, then 200s), with the model:
  - outputs match the model's quarter-filter values in order.
  - the first window has [63:56]=200 and [55:0]=0.
- Backpressure: frac=2, out_ready low for 20 cycles starting after the 2nd output:
  - pix_ready drops once credits reach 0; no result is lost or duplicated.
  - the buffer holds exactly OBUF_DEPTH entries; the row completes after out_ready returns high.
- Reset asserted for 1 cycle after the 5th output of a row:
  - next cycle: all outputs 0 and no done.
  - a following start/row with ramp input produces the correct 8 outputs.
- start pulsed during RUN, and pix_valid held high in DRAIN:
  - both are ignored; only ROW_W+7 pixels are accepted.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared definitions for the HEVC luma row interpolation scheduler:
// fractional-position codes, window geometry and FSM state encoding.
package interp_pkg;

  localparam logic [1:0] FRAC_INT = 2'd0;
  localparam logic [1:0] FRAC_Q   = 2'd1;
  localparam logic [1:0] FRAC_H   = 2'd2;
  localparam logic [1:0] FRAC_3Q  = 2'd3;

  localparam int FIR_TAPS = 8;
  localparam int PRE_PIX  = FIR_TAPS - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // True when the FIR bank result is used rather than the bypassed centre tap.
  function automatic logic is_filtered(input logic [1:0] f);
    return (f == FRAC_Q) || (f == FRAC_H) || (f == FRAC_3Q);
  endfunction

endpackage

// File: rtl/interp_result_fifo.sv
// First-word-fall-through result FIFO (data + last flag) with occupancy count.
module interp_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign do_rd = rd_en && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a write.
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr_reg];
  assign count   = count_reg;

  overflow_chk : assert property (@(posedge clk) disable iff (srst) !(wr_en && full && !do_rd));

endmodule

// File: rtl/interp_row_scheduler.sv
// Sequences one row of luma sub-pixel interpolation through the shared FIR bank,
// issuing windows only while result-buffer credits remain.
module interp_row_scheduler
  import interp_pkg::*;
#(
  parameter int ROW_W      = 8,
  parameter int FIR_LAT    = 1,
  parameter int OBUF_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  frac,
  output logic        busy,
  output logic        done,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  output logic        win_valid,
  output logic [63:0] win_data,
  output logic [1:0]  win_sel,
  input  logic [7:0]  fir_subpixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last
);

  localparam int IW = $clog2(ROW_W + 1);
  localparam int CW = $clog2(OBUF_DEPTH + 1);

  state_t             state_reg;
  state_t             state_next;
  logic [1:0]         frac_reg;
  logic [63:0]        window_reg;
  logic [63:0]        window_next;
  logic [63:0]        win_data_reg;
  logic               win_valid_reg;
  logic               win_last_reg;
  logic               done_reg;
  logic [2:0]         pre_cnt_reg;
  logic [IW-1:0]      issued_reg;
  logic [FIR_LAT-1:0] vld_pipe_reg;
  logic [FIR_LAT-1:0] last_pipe_reg;
  logic [7:0]         byte_pipe_reg [FIR_LAT];

  logic               ready_c;
  logic               accept;
  logic               issue;
  logic               credit_avail;
  logic [3:0]         inflight;
  logic               fifo_empty;
  logic [8:0]         fifo_wr_data;
  logic [8:0]         fifo_rd_data;
  logic [CW-1:0]      fifo_count;

  assign window_next = {pix_data, window_reg[63:8]};
  assign accept      = pix_valid && ready_c;
  assign issue       = accept && (state_reg == RUN);

  // Every issued window holds a slot from issue until its result is popped.
  always_comb begin
    inflight = {3'b000, win_valid_reg};
    for (int k = 0; k < FIR_LAT; k++) begin
      inflight = inflight + {3'b000, vld_pipe_reg[k]};
    end
  end

  assign credit_avail = (int'(fifo_count) + int'(inflight)) < OBUF_DEPTH;

  always_comb begin
    state_next = state_reg;
    ready_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = PRELOAD;
      end
      PRELOAD: begin
        ready_c = 1'b1;
        if (pix_valid && (pre_cnt_reg == 3'(PRE_PIX - 1))) state_next = RUN;
      end
      RUN: begin
        ready_c = credit_avail && (issued_reg < IW'(ROW_W));
        if (pix_valid && ready_c && (issued_reg == IW'(ROW_W - 1))) state_next = DRAIN;
      end
      DRAIN: begin
        if (!fifo_empty && out_ready && fifo_rd_data[8]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      frac_reg      <= '0;
      window_reg    <= '0;
      win_data_reg  <= '0;
      win_valid_reg <= 1'b0;
      win_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
      pre_cnt_reg   <= '0;
      issued_reg    <= '0;
      vld_pipe_reg  <= '0;
      last_pipe_reg <= '0;
      for (int k = 0; k < FIR_LAT; k++) byte_pipe_reg[k] <= '0;
    end else begin
      state_reg     <= state_next;
      done_reg      <= (state_reg == DRAIN) && (state_next == IDLE);
      win_valid_reg <= issue;
      if ((state_reg == IDLE) && start) begin
        frac_reg    <= frac;
        pre_cnt_reg <= '0;
        issued_reg  <= '0;
        window_reg  <= '0;
      end
      if (accept) window_reg <= window_next;
      if (accept && (state_reg == PRELOAD)) pre_cnt_reg <= pre_cnt_reg + 3'd1;
      if (issue) begin
        issued_reg   <= issued_reg + 1'b1;
        win_data_reg <= window_next;
        win_last_reg <= (issued_reg == IW'(ROW_W - 1));
      end
      // Tag pipe tracks the FIR bank; the byte pipe carries the centre tap for integer rows.
      vld_pipe_reg[0]  <= win_valid_reg;
      last_pipe_reg[0] <= win_last_reg;
      byte_pipe_reg[0] <= win_data_reg[31:24];
      for (int k = 1; k < FIR_LAT; k++) begin
        vld_pipe_reg[k]  <= vld_pipe_reg[k-1];
        last_pipe_reg[k] <= last_pipe_reg[k-1];
        byte_pipe_reg[k] <= byte_pipe_reg[k-1];
      end
    end
  end

  assign fifo_wr_data = {last_pipe_reg[FIR_LAT-1],
                         is_filtered(frac_reg) ? fir_subpixel : byte_pipe_reg[FIR_LAT-1]};

  interp_result_fifo #(
    .DEPTH (OBUF_DEPTH),
    .WIDTH (9)
  ) u_result_fifo (
    .clk     (clock),
    .srst    (reset),
    .wr_en   (vld_pipe_reg[FIR_LAT-1]),
    .wr_data (fifo_wr_data),
    .rd_en   (out_ready),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign pix_ready = ready_c;
  assign win_valid = win_valid_reg;
  assign win_data  = win_data_reg;
  assign win_sel   = frac_reg;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd_data[7:0];
  assign out_last  = fifo_rd_data[8];

endmodule

// File: tb/tb_interp_row_scheduler.sv
// Directed bench for interp_row_scheduler with a behavioural FIR bank attached.
module tb_interp_row_scheduler;

  localparam int ROW_W      = 8;
  localparam int FIR_LAT    = 1;
  localparam int OBUF_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  frac;
  logic        busy;
  logic        done;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        win_valid;
  logic [63:0] win_data;
  logic [1:0]  win_sel;
  logic [7:0]  fir_subpixel;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  interp_row_scheduler #(
    .ROW_W      (ROW_W),
    .FIR_LAT    (FIR_LAT),
    .OBUF_DEPTH (OBUF_DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .frac         (frac),
    .busy         (busy),
    .done         (done),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .win_valid    (win_valid),
    .win_data     (win_data),
    .win_sel      (win_sel),
    .fir_subpixel (fir_subpixel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // HEVC luma filters, 6-bit rounding, clipped to 8 bits.
  function automatic logic [7:0] fir_model(input logic [63:0] w, input logic [1:0] sel);
    int c [8];
    int acc;
    case (sel)
      2'd1:    c = '{-1, 4, -10, 58, 17, -5, 1, 0};
      2'd2:    c = '{-1, 4, -11, 40, 40, -11, 4, -1};
      2'd3:    c = '{0, 1, -5, 17, 58, -10, 4, -1};
      default: c = '{0, 0, 0, 64, 0, 0, 0, 0};
    endcase
    acc = 32;
    for (int k = 0; k < 8; k++) acc += c[k] * int'(w[8*k +: 8]);
    acc = acc >>> 6;
    if (acc < 0) return 8'd0;
    if (acc > 255) return 8'd255;
    return 8'(acc);
  endfunction

  int          cyc = 0;
  int          acc_cnt = 0;
  int          out_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_pop_cyc = 0;
  int          issue_cnt = 0;
  int          sel_bad = 0;
  logic [7:0]  got_data [128];
  logic        got_last [128];
  logic [63:0] win_log [128];
  logic [1:0]  exp_sel = 2'd0;
  logic [7:0]  src_pix [32];
  int          src_len = 0;
  int          src_gen = 0;
  bit          src_en = 1'b0;
  logic [7:0]  exp_row [8];

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Pixel source: one pixel per handshake from src_pix, restarted on src_gen change.
  initial begin
    int idx;
    int seen_gen;
    bit fire;
    idx = 0;
    seen_gen = 0;
    pix_valid = 1'b0;
    pix_data = 8'd0;
    forever begin
      @(negedge clock);
      fire = pix_valid && pix_ready;
      @(posedge clock);
      #1;
      if (fire) begin
        idx++;
        acc_cnt++;
      end
      if (src_gen != seen_gen) begin
        seen_gen = src_gen;
        idx = 0;
      end
      if (src_en && idx < src_len) begin
        pix_valid = 1'b1;
        pix_data = src_pix[idx];
      end else begin
        pix_valid = 1'b0;
        pix_data = 8'd0;
      end
    end
  end

  // Behavioural FIR bank, latency FIR_LAT = 1.
  initial begin
    logic [7:0] pend;
    fir_subpixel = 8'd0;
    forever begin
      @(negedge clock);
      pend = win_valid ? fir_model(win_data, win_sel) : 8'd0;
      @(posedge clock);
      #1;
      fir_subpixel = pend;
    end
  end

  // Monitor: output pops, done pulses and issued windows.
  initial forever begin
    @(negedge clock);
    if (out_valid && out_ready) begin
      if (out_cnt < 128) begin
        got_data[out_cnt] = out_data;
        got_last[out_cnt] = out_last;
      end
      out_cnt++;
      if (out_last) last_pop_cyc = cyc;
      $display("pop  #%0d data=%0d last=%0b", out_cnt, out_data, out_last);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (win_valid) begin
      if (issue_cnt < 128) win_log[issue_cnt] = win_data;
      issue_cnt++;
      if (win_sel != exp_sel) sel_bad++;
    end
  end

  task automatic load_src(input int pat, input int n);
    for (int k = 0; k < n; k++) begin
      case (pat)
        0:       src_pix[k] = 8'(k);
        1:       src_pix[k] = 8'd100;
        default: src_pix[k] = (k < 7) ? 8'd0 : 8'd200;
      endcase
    end
    src_len = n;
    src_en = 1'b1;
    src_gen++;
  endtask

  task automatic start_row(input logic [1:0] f);
    @(posedge clock);
    #1;
    frac = f;
    exp_sel = f;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    frac = 2'd0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int i;
    i = 0;
    while (done_cnt == d0 && i < 2000) begin
      @(negedge clock);
      i++;
    end
    check(tag, 64'(done_cnt > d0), 64'd1);
  endtask

  task automatic check_row(input string tag, input int ob, input int ab, input int ib, input int sb);
    int n_early;
    repeat (3) @(negedge clock);
    check({tag, "_outs"}, 64'(out_cnt - ob), 64'(ROW_W));
    n_early = 0;
    for (int k = 0; k < ROW_W; k++) begin
      check($sformatf("%s_d%0d", tag, k), 64'(got_data[ob+k]), 64'(exp_row[k]));
      if (k < ROW_W - 1 && got_last[ob+k]) n_early++;
    end
    check({tag, "_last_early"}, 64'(n_early), 64'd0);
    check({tag, "_last"}, 64'(got_last[ob+ROW_W-1]), 64'd1);
    check({tag, "_pix_acc"}, 64'(acc_cnt - ab), 64'(ROW_W + 7));
    check({tag, "_issues"}, 64'(issue_cnt - ib), 64'(ROW_W));
    check({tag, "_done_lat"}, 64'(done_cyc - last_pop_cyc), 64'd1);
    check({tag, "_sel"}, 64'(sel_bad - sb), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  int ob, ab, ib, sb, db, i;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    frac = 2'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pix_ready", 64'(pix_ready), 64'd0);
    check("rst_win_valid", 64'(win_valid), 64'd0);
    check("rst_win_data", win_data, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;

    // Integer position, ramp input: centre taps 3..10.
    ob = out_cnt; ab = acc_cnt; ib = issue_cnt; sb = sel_bad; db = done_cnt;
    load_src(0, ROW_W + 7);
    start_row(2'd0);
    wait_done("t1_done", db);
    for (int k = 0; k < ROW_W; k++) exp_row[k] = 8'(k + 3);
    check_row("t1", ob, ab, ib, sb);

    // Half-pel, constant 100.
    ob = out_cnt; ab = acc_cnt; ib = issue_cnt; sb = sel_bad; db = done_cnt;
    load_src(1, ROW_W + 7);
    start_row(2'd2);
    wait_done("t2_done", db);
    for (int k = 0; k < ROW_W; k++) exp_row[k] = 8'd100;
    check_row("t2", ob, ab, ib, sb);
    check("t2_first_win", win_log[ib], 64'h6464646464646464);

    // Quarter-pel, step 0 -> 200 after 7 pixels.
    ob = out_cnt; ab = acc_cnt; ib = issue_cnt; sb = sel_bad; db = done_cnt;
    load_src(2, ROW_W + 7);
    start_row(2'd1);
    wait_done("t3_done", db);
    exp_row = '{8'd0, 8'd3, 8'd0, 8'd41, 8'd222, 8'd191, 8'd203, 8'd200};
    check_row("t3", ob, ab, ib, sb);
    check("t3_first_win", win_log[ib], 64'hC800000000000000);

    // Backpressure: hold out_ready low for 20 cycles after the 2nd output.
    ob = out_cnt; ab = acc_cnt; ib = issue_cnt; sb = sel_bad; db = done_cnt;
    load_src(1, ROW_W + 7);
    start_row(2'd2);
    i = 0;
    while (out_cnt < ob + 2 && i < 500) begin
      @(negedge clock);
      i++;
    end
    check("t4_reach2", 64'(out_cnt >= ob + 2), 64'd1);
    out_ready = 1'b0;
    repeat (20) @(negedge clock);
    check("t4_pix_ready", 64'(pix_ready), 64'd0);
    check("t4_obuf_full", 64'(dut.fifo_count), 64'(OBUF_DEPTH));
    check("t4_out_valid", 64'(out_valid), 64'd1);
    check("t4_stalled", 64'(acc_cnt - ab < ROW_W + 7), 64'd1);
    check("t4_no_done", 64'(done_cnt - db), 64'd0);
    out_ready = 1'b1;
    wait_done("t4_done", db);
    for (int k = 0; k < ROW_W; k++) exp_row[k] = 8'd100;
    check_row("t4", ob, ab, ib, sb);

    // Reset after the 5th output of a ramp row.
    ob = out_cnt; db = done_cnt;
    load_src(0, ROW_W + 7);
    start_row(2'd0);
    i = 0;
    while (out_cnt < ob + 5 && i < 500) begin
      @(negedge clock);
      i++;
    end
    check("t5_reach5", 64'(out_cnt >= ob + 5), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    src_en = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_pix_ready", 64'(pix_ready), 64'd0);
    check("t5_win_valid", 64'(win_valid), 64'd0);
    check("t5_win_data", win_data, 64'd0);
    check("t5_win_sel", 64'(win_sel), 64'd0);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_out_data", 64'(out_data), 64'd0);
    check("t5_out_last", 64'(out_last), 64'd0);
    repeat (10) @(negedge clock);
    check("t5_no_done", 64'(done_cnt - db), 64'd0);

    ob = out_cnt; ab = acc_cnt; ib = issue_cnt; sb = sel_bad; db = done_cnt;
    load_src(0, ROW_W + 7);
    start_row(2'd0);
    wait_done("t5b_done", db);
    for (int k = 0; k < ROW_W; k++) exp_row[k] = 8'(k + 3);
    check_row("t5b", ob, ab, ib, sb);

    // start pulsed during RUN; surplus pixels stay valid through DRAIN.
    ob = out_cnt; ab = acc_cnt; ib = issue_cnt; sb = sel_bad; db = done_cnt;
    load_src(0, 24);
    start_row(2'd0);
    i = 0;
    while (issue_cnt < ib + 3 && i < 500) begin
      @(negedge clock);
      i++;
    end
    check("t6_reach_run", 64'(issue_cnt >= ib + 3), 64'd1);
    @(posedge clock);
    #1;
    start = 1'b1;
    frac = 2'd2;
    @(posedge clock);
    #1;
    start = 1'b0;
    frac = 2'd0;
    wait_done("t6_done", db);
    check_row("t6", ob, ab, ib, sb);
    check("t6_win_sel", 64'(win_sel), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
